// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter for 4 requesters onto one FIFO write port.
// Optional macro FIFO_ARB_STALL_STATS_EN adds a saturating stall_cnt output.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               wr_clk,
    input  logic               reset,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] req_data,
    input  logic               wr_full,
    output logic [3:0]         grant,
    output logic               fifo_wr_en,
    output logic [WIDTH-1:0]   fifo_data_in,
    output logic [1:0]         active_id,
    output logic               busy
`ifdef FIFO_ARB_STALL_STATS_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    localparam logic [3:0] LAST = 4'(MAX_BURST - 1);

    state_t     state;
    logic [1:0] rr_ptr;
    logic [3:0] burst_cnt;
    logic [1:0] pick_id;
    logic       burst_end;

    // Round-robin search: first set req bit at rr_ptr, rr_ptr+1, ... mod 4.
    always_comb begin
        pick_id = rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[rr_ptr + 2'(k)]) begin
                pick_id = rr_ptr + 2'(k);
            end
        end
    end

    assign fifo_wr_en   = |(grant & req) & ~wr_full;
    assign fifo_data_in = req_data[active_id*WIDTH +: WIDTH];

    // Burst closes on its last accepted word or when the owner withdraws.
    assign burst_end = ~req[active_id] |
                       (fifo_wr_en & (burst_cnt == LAST));

    // Two-state grant FSM with registered grant/active_id/busy.
    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            active_id <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state     <= BURST;
                        grant     <= 4'b0001 << pick_id;
                        active_id <= pick_id;
                        burst_cnt <= '0;
                        busy      <= 1'b1;
                    end
                end
                BURST: begin
                    if (burst_end) begin
                        state  <= IDLE;
                        grant  <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= active_id + 2'd1;
                    end else if (fifo_wr_en) begin
                        burst_cnt <= burst_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_ARB_STALL_STATS_EN
    // Count burst cycles lost to a full FIFO, saturating at all ones.
    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (busy && wr_full && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: cycle vector table for grant/strobe plus a
// write-data scoreboard; honours FIFO_ARB_STALL_STATS_EN when defined.
module tb_fifo_wr_arbiter;

    localparam int W = 8;

    logic           wr_clk;
    logic           reset;
    logic [3:0]     req;
    logic [4*W-1:0] req_data;
    logic           wr_full;
    logic [3:0]     grant;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_data_in;
    logic [1:0]     active_id;
    logic           busy;
`ifdef FIFO_ARB_STALL_STATS_EN
    logic [15:0]    stall_cnt;
`endif

    fifo_wr_arbiter #(.WIDTH(W), .MAX_BURST(4)) dut (
        .wr_clk       (wr_clk),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .wr_full      (wr_full),
        .grant        (grant),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .active_id    (active_id),
        .busy         (busy)
`ifdef FIFO_ARB_STALL_STATS_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        full;
        logic [3:0]  eg;
        logic        ew;
        logic        cs;
        logic [15:0] es;
    } vec_t;

    vec_t       vq[$];
    logic [7:0] sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_exp_wr = 0;
    int         n_got_wr = 0;
    int         cur_step = 0;

    function automatic void add(input int n, input logic r,
                                input logic [3:0] rq, input logic f,
                                input logic [3:0] g, input logic w,
                                input logic cs = 1'b0,
                                input logic [15:0] es = 16'd0);
        vec_t v;
        v.rst = r; v.req = rq; v.full = f;
        v.eg = g; v.ew = w; v.cs = cs; v.es = es;
        for (int i = 0; i < n; i++) vq.push_back(v);
    endfunction

    function automatic logic [1:0] oh2i(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h",
                     nm, cur_step, act, exp);
        end
    endtask

    // Scoreboard: every observed write must match the oldest expected word.
    always @(negedge wr_clk) begin
        #4;
        if (fifo_wr_en === 1'b1) begin
            n_got_wr++;
            if (sb.size() == 0) begin
                chk("unexpected_write", {24'd0, fifo_data_in}, 32'hFFFF_FFFF);
            end else begin
                chk("write_data", {24'd0, fifo_data_in},
                    {24'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        reset    = 1'b1;
        req      = '0;
        wr_full  = 1'b0;
        req_data = '0;

        // Case 1: single requester 2, burst of 4, one idle, re-grant.
        add(1, 1, 4'b0000, 0, 4'b0000, 0);
        add(1, 0, 4'b0100, 0, 4'b0000, 0);
        add(4, 0, 4'b0100, 0, 4'b0100, 1);
        add(1, 0, 4'b0100, 0, 4'b0000, 0);
        add(1, 0, 4'b0000, 0, 4'b0100, 0);
        add(1, 0, 4'b0000, 0, 4'b0000, 0);
        // Case 2: all requesting, order 0,1,2,3,0.
        add(1, 1, 4'b0000, 0, 4'b0000, 0);
        add(1, 0, 4'b1111, 0, 4'b0000, 0);
        for (int i = 0; i < 4; i++) begin
            add(4, 0, 4'b1111, 0, 4'b0001 << i, 1);
            add(1, 0, 4'b1111, 0, 4'b0000, 0);
        end
        add(4, 0, 4'b1111, 0, 4'b0001, 1);
        add(1, 0, 4'b0000, 0, 4'b0000, 0);
        // Case 3: 5-cycle stall after the 2nd write.
        add(1, 0, 4'b0010, 0, 4'b0000, 0);
        add(2, 0, 4'b0010, 0, 4'b0010, 1);
        add(5, 0, 4'b0010, 1, 4'b0010, 0);
        add(2, 0, 4'b0010, 0, 4'b0010, 1);
        add(1, 0, 4'b0000, 0, 4'b0000, 0, 1, 16'd5);
        // Case 4: requester 1 withdraws after 2 writes; rr_ptr -> 2.
        add(1, 0, 4'b0010, 0, 4'b0000, 0);
        add(2, 0, 4'b0010, 0, 4'b0010, 1);
        add(1, 0, 4'b0000, 0, 4'b0010, 0);
        add(1, 0, 4'b0110, 0, 4'b0000, 0);
        add(1, 0, 4'b0110, 0, 4'b0100, 1);
        add(1, 0, 4'b0000, 0, 4'b0100, 0);
        add(1, 0, 4'b0000, 0, 4'b0000, 0);
        // Full and withdraw in the same cycle: end with no write.
        add(1, 0, 4'b1000, 0, 4'b0000, 0);
        add(1, 0, 4'b1000, 0, 4'b1000, 1);
        add(1, 0, 4'b0000, 1, 4'b1000, 0);
        add(1, 0, 4'b0000, 0, 4'b0000, 0, 1, 16'd6);
        // Long stall holds the grant and the burst count.
        add(1, 0, 4'b0001, 0, 4'b0000, 0);
        add(1, 0, 4'b0001, 0, 4'b0001, 1);
        add(20, 0, 4'b0001, 1, 4'b0001, 0);
        add(3, 0, 4'b0001, 0, 4'b0001, 1);
        add(1, 0, 4'b0000, 0, 4'b0000, 0, 1, 16'd26);
        // Case 5: reset in 3rd burst cycle, then requester 0 first.
        add(1, 0, 4'b0100, 0, 4'b0000, 0);
        add(2, 0, 4'b0100, 0, 4'b0100, 1);
        add(1, 1, 4'b0100, 0, 4'b0000, 0, 1, 16'd0);
        add(1, 0, 4'b1111, 0, 4'b0000, 0);
        add(1, 0, 4'b1111, 0, 4'b0001, 1);
        add(1, 0, 4'b0000, 0, 4'b0001, 0);
        add(1, 0, 4'b0000, 0, 4'b0000, 0, 1, 16'd0);

        foreach (vq[s]) begin
            @(negedge wr_clk);
            cur_step = s;
            reset    = vq[s].rst;
            req      = vq[s].req;
            wr_full  = vq[s].full;
            for (int i = 0; i < 4; i++)
                req_data[i*W +: W] = 8'(i*64 + (s % 64));
            #2;
            chk("grant", {28'd0, grant}, {28'd0, vq[s].eg});
            chk("fifo_wr_en", {31'd0, fifo_wr_en}, {31'd0, vq[s].ew});
            chk("busy", {31'd0, busy}, {31'd0, |vq[s].eg});
            if (vq[s].eg != 4'd0)
                chk("active_id", {30'd0, active_id}, {30'd0, oh2i(vq[s].eg)});
            if (vq[s].ew) begin
                sb.push_back(8'(oh2i(vq[s].eg) * 64 + (s % 64)));
                n_exp_wr++;
            end
`ifdef FIFO_ARB_STALL_STATS_EN
            if (vq[s].cs)
                chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, vq[s].es});
`endif
        end

        // Asynchronous reset away from any edge while stalled.
        cur_step = -1;
        @(negedge wr_clk);
        req     = 4'b0010;
        wr_full = 1'b0;
        @(negedge wr_clk);
        wr_full = 1'b1;
        #2;
        chk("grant_before_async_rst", {28'd0, grant}, 32'd2);
        @(posedge wr_clk);
        #2;
        reset = 1'b1;
        #1;
        chk("grant_async_rst", {28'd0, grant}, 32'd0);
        chk("busy_async_rst", {31'd0, busy}, 32'd0);
        chk("active_id_async_rst", {30'd0, active_id}, 32'd0);
        @(negedge wr_clk);
        reset   = 1'b0;
        req     = 4'b0000;
        wr_full = 1'b0;
        @(negedge wr_clk);
        #2;
        chk("grant_after_async_rst", {28'd0, grant}, 32'd0);

        @(negedge wr_clk);
        #6;
        chk("scoreboard_empty", sb.size(), 32'd0);
        chk("write_count", n_got_wr, n_exp_wr);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data width of each requester and of the FIFO write port.
REQ-002 Parameter MAX_BURST, default 4: maximum words accepted per grant; legal range 1..15.
REQ-003 Parameter NUM_REQ is fixed at 4 requesters; requester index i is 0..3.
REQ-004 wr_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  4  req[i] high: requester i holds a valid word.
REQ-007 req_data  input  4*WIDTH  word of requester i on bits [i*WIDTH +: WIDTH].
REQ-008 wr_full  input  1  FIFO full flag, write-clock domain.
REQ-009 grant  output  4  one-hot or zero, registered; current owner of the write port.
REQ-010 fifo_wr_en  output  1  FIFO write strobe.
REQ-011 fifo_data_in  output  WIDTH  word written to the FIFO.
REQ-012 active_id  output  2  registered index of the granted requester.
REQ-013 busy  output  1  high while in state BURST.

Function
REQ-014 The FSM SHALL have two states, IDLE and BURST.
REQ-015 IDLE SHALL move to BURST on the next edge when req is nonzero, granting the first set req bit searching from rr_ptr upward with wrap-around (rr_ptr, rr_ptr+1, ..., mod 4).
REQ-016 IDLE with req equal to 0 SHALL remain IDLE with grant at 0.
REQ-017 fifo_wr_en SHALL be combinational: |(grant & req) & ~wr_full.
REQ-018 fifo_data_in SHALL equal req_data of active_id in every cycle; it is don't-care when fifo_wr_en is 0.
REQ-019 A word is accepted in every cycle with fifo_wr_en high; the requester holds req and its data until acceptance.
REQ-020 In BURST, burst_cnt (4-bit) SHALL increment on each acceptance and clear on entry to BURST.
REQ-021 BURST SHALL end, returning to IDLE with grant at 0 on the next edge, when the accepted word is the MAX_BURST-th of the grant, or when req[active_id] is low.
REQ-022 On burst end, rr_ptr SHALL become (active_id+1) mod 4.
REQ-023 Every burst end SHALL be followed by exactly one IDLE cycle, so the minimum gap between grants to different requesters is 1 cycle.
REQ-024 While wr_full is high in BURST with req held, the block SHALL stall: no write, burst_cnt held, grant held, indefinitely.
REQ-025 When wr_full is high and req[active_id] drops in the same cycle, the burst SHALL end without a write.
REQ-026 Requests from non-granted requesters SHALL have no effect on an ongoing burst.
REQ-027 No requester SHALL wait more than 3 bursts while continuously requesting.

Reset
REQ-028 While reset is high: state IDLE, grant 0, active_id 0, rr_ptr 0, burst_cnt 0, busy 0; hence fifo_wr_en 0.
REQ-029 Reset asserted mid-burst SHALL clear grant immediately and discard the burst with no further write.
REQ-030 Arbitration SHALL resume with the first wr_clk edge after reset deasserts.

Configuration
REQ-031 When macro FIFO_ARB_STALL_STATS_EN is defined, the block SHALL add output stall_cnt [15:0].
REQ-032 With the macro defined, stall_cnt SHALL count cycles with busy and wr_full both high, saturate at 16'hFFFF, and reset to 0.
REQ-033 Without the macro, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-034 Case 1: after reset, req=4'b0100 held with wr_full=0 and MAX_BURST=4. Expect: grant=4'b0100 on edge 1, writes on 4 consecutive cycles, then 1 IDLE cycle, then re-grant to requester 2.
REQ-035 Case 2: req=4'b1111 held with wr_full=0. Expect: grant order 0,1,2,3,0, with 4 writes per grant separated by single IDLE cycles.
REQ-036 Case 3: wr_full=1 for 5 cycles after the 2nd write of a burst. Expect: no fifo_wr_en during those cycles, grant held, 2 further writes after release, and stall_cnt=5 when the macro is defined.
REQ-037 Case 4: requester 1 drops req after 2 writes. Expect: burst ends, rr_ptr=2, and requester 2 is granted next when req=4'b0110.
REQ-038 Case 5: reset pulse during the 3rd cycle of a burst. Expect: grant=0 and fifo_wr_en=0 immediately, and requester 0 is granted first after release with req=4'b1111.
